in_fea_stream_buf: RTL and testbench

Parametrised on-chip store for the global input feature map, with a write-load port and a streaming read port.
- Streams a configurable window of ELEMS-wide vectors from a pipelined BRAM, using valid/ready backpressure, prefetch and single-pass or looping mode.
- Sits between the host load path and the compute array's input feature consumer.
- Replaces the fixed 25x1, request-per-vector reader with a sustained 1 vector/cycle stream.

---
 rtl/in_fea_pkg.sv | 20 ++
 rtl/in_fea_stream_buf_if.sv | 28 ++
 rtl/in_fea_ram.sv | 35 +++
 rtl/in_fea_stream_buf.sv | 185 ++++++++++++++++++
 tb/tb_in_fea_stream_buf.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/in_fea_pkg.sv
// Shared constants, state encoding and width helper for the input feature
// map stream buffer.
package in_fea_pkg;

    localparam int ELEM_W_DEF = 16;
    localparam int ELEMS_DEF  = 25;
    localparam int DEPTH_DEF  = 450;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    function automatic int vec_w(input int elem_w, input int elems);
        return elem_w * elems;
    endfunction

endpackage

// File: rtl/in_fea_stream_buf_if.sv
// Valid/ready stream carrying feature vectors from the buffer to the
// compute array's input consumer.
interface in_fea_stream_buf_if
    import in_fea_pkg::*;
#(
    parameter int VEC_W = vec_w(ELEM_W_DEF, ELEMS_DEF)
) ();

    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_data;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/in_fea_ram.sv
// Simple dual-port feature RAM: one write port, one read-first read port
// with an RD_LAT-stage registered output pipe.
module in_fea_ram
    import in_fea_pkg::*;
#(
    parameter int W      = vec_w(ELEM_W_DEF, ELEMS_DEF),
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_data
);

    logic [W-1:0] mem  [DEPTH];
    logic [W-1:0] rd_q [RD_LAT];

    // Read and write share one process so a same-address access returns old data.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH))) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q[0] <= mem[rd_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            rd_q[i] <= rd_q[i-1];
        end
    end

    assign rd_data = rd_q[RD_LAT-1];

endmodule

// File: rtl/in_fea_stream_buf.sv
// Streams a window of feature vectors out of the on-chip RAM at one vector
// per cycle, using a credit-limited prefetch into a small output FIFO.
module in_fea_stream_buf
    import in_fea_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int ELEMS  = ELEMS_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 2,
    parameter int FIFO_D = RD_LAT + 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          cfg_base,
    input  logic [ADDR_W:0]            cfg_len,
    input  logic                       cfg_loop,
    input  logic                       stop,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [ELEM_W*ELEMS-1:0]    wr_data,
    in_fea_stream_buf_if.master        strm,
    output logic                       busy,
    output logic                       done
);

    localparam int VEC_W = vec_w(ELEM_W, ELEMS);
    localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CNT_W = $clog2(FIFO_D + 1);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q, addr_q;
    logic [ADDR_W:0]   len_q, pass_q;
    logic              loop_q, stop_q;
    logic [RD_LAT-1:0] vld_q, tag_q;
    logic [CNT_W-1:0]  inflight_q, count_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [VEC_W-1:0]  fifo_data_q [FIFO_D];
    logic              fifo_last_q [FIFO_D];

    logic             issue, pass_end, credit_ok, push, pop, drain_empty;
    logic [VEC_W-1:0] rd_data;

    in_fea_ram #(
        .W      (VEC_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (addr_q),
        .rd_data (rd_data)
    );

    // Reads in flight plus entries already queued may never exceed the FIFO.
    assign credit_ok   = ({1'b0, inflight_q} + {1'b0, count_q}) < (CNT_W+1)'(FIFO_D);
    assign issue       = (state_q == RUN) && credit_ok;
    assign pass_end    = (pass_q == len_q - 1'b1);
    assign push        = vld_q[RD_LAT-1];
    assign pop         = strm.out_valid && strm.out_ready;
    assign drain_empty = (inflight_q == '0) &&
                         ((count_q == '0) || ((count_q == CNT_W'(1)) && pop));

    assign strm.out_valid = (count_q != '0);
    assign strm.out_data  = fifo_data_q[rd_ptr_q];
    assign strm.out_last  = fifo_last_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (cfg_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (issue && pass_end && (!loop_q || stop_q || stop)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q     <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            pass_q     <= '0;
            loop_q     <= 1'b0;
            stop_q     <= 1'b0;
            vld_q      <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            if ((state_q == IDLE) && start) begin
                base_q <= cfg_base;
                addr_q <= cfg_base;
                len_q  <= cfg_len;
                loop_q <= cfg_loop;
                pass_q <= '0;
                stop_q <= 1'b0;
            end else if (busy && stop) begin
                stop_q <= 1'b1;
            end

            if (issue) begin
                if (pass_end) begin
                    pass_q <= '0;
                    addr_q <= base_q;
                end else begin
                    pass_q <= pass_q + 1'b1;
                    addr_q <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                end
            end

            // Valid and last-tag pipes run in lockstep with the RAM read pipe.
            vld_q[0] <= issue;
            tag_q[0] <= issue && pass_end;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end

            case ({issue, push})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase

            if (push) begin
                fifo_data_q[wr_ptr_q] <= rd_data;
                fifo_last_q[wr_ptr_q] <= tag_q[RD_LAT-1];
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr_q + 1'b1;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count_q == CNT_W'(FIFO_D))));

endmodule

// File: tb/tb_in_fea_stream_buf.sv
// Directed bench for in_fea_stream_buf: latency, wrap, backpressure, looping,
// zero-length runs, ignored restarts and mid-run reset.
module tb_in_fea_stream_buf;
    import in_fea_pkg::*;

    localparam int ELEM_W = 16;
    localparam int ELEMS  = 25;
    localparam int DEPTH  = 450;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int RD_LAT = 2;
    localparam int VEC_W  = ELEM_W * ELEMS;
    localparam int LIMIT  = 3000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [ADDR_W:0]   cfg_len = '0;
    logic              cfg_loop = 1'b0;
    logic              stop = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [VEC_W-1:0]  wr_data = '0;
    logic              busy, done;

    in_fea_stream_buf_if #(.VEC_W(VEC_W)) strm ();

    in_fea_stream_buf #(
        .ELEM_W (ELEM_W),
        .ELEMS  (ELEMS),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .cfg_loop (cfg_loop),
        .stop     (stop),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .strm     (strm),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int bq_val[$];
    bit bq_last[$];
    int bq_cyc[$];
    int first_valid, done_cyc, done_cnt, stall_viol, extra_valid, bad_uniform;
    int busy_at_done, busy_seen, timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VEC_W-1:0] vec_of(input int k);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int e = 0; e < ELEMS; e++) v[e*ELEM_W +: ELEM_W] = ELEM_W'(k);
        return v;
    endfunction

    function automatic bit uniform(input logic [VEC_W-1:0] d);
        for (int e = 1; e < ELEMS; e++)
            if (d[e*ELEM_W +: ELEM_W] !== d[ELEM_W-1:0]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_all();
        for (int k = 0; k < DEPTH; k++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(k); wr_data = vec_of(k);
            tick();
        end
        wr_en = 1'b0;
        tick();
    endtask

    // Runs one stream: start is high in cycle c=0; records every handshake.
    task automatic collect(input int base, input int len, input bit loop_en,
                           input int pct, input int stop_cyc, input int restart_cyc);
        logic [VEC_W-1:0] prev_data;
        logic prev_last, prev_stall;
        int c;
        bq_val.delete(); bq_last.delete(); bq_cyc.delete();
        first_valid = -1; done_cyc = -1; done_cnt = 0; stall_viol = 0;
        extra_valid = 0; bad_uniform = 0; busy_at_done = -1; busy_seen = 0; timeout = 0;
        cfg_base = ADDR_W'(base); cfg_len = (ADDR_W+1)'(len); cfg_loop = loop_en;
        start = 1'b1; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; c = 0;
        while (1) begin
            stop = (c == stop_cyc);
            if (c == restart_cyc) begin
                start = 1'b1; cfg_base = ADDR_W'(100); cfg_len = (ADDR_W+1)'(1); cfg_loop = 1'b0;
            end else if (c > 0) begin
                start = 1'b0;
            end
            strm.out_ready = ($urandom_range(99) < pct);
            if (busy) busy_seen = 1;
            if (strm.out_valid) begin
                if (first_valid < 0) first_valid = c;
                if (done_cyc >= 0) extra_valid++;
                if (prev_stall && (strm.out_data !== prev_data || strm.out_last !== prev_last))
                    stall_viol++;
                if (!uniform(strm.out_data)) bad_uniform++;
            end
            if (strm.out_valid && strm.out_ready) begin
                bq_val.push_back(int'(strm.out_data[ELEM_W-1:0]));
                bq_last.push_back(strm.out_last);
                bq_cyc.push_back(c);
            end
            prev_stall = strm.out_valid && !strm.out_ready;
            prev_data = strm.out_data;
            prev_last = strm.out_last;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; busy_at_done = int'(busy); end
            end
            if (done_cyc >= 0 && c >= done_cyc + 5) break;
            if (c >= LIMIT) begin timeout = 1; break; end
            tick();
            c++;
        end
        start = 1'b0; stop = 1'b0; strm.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        tests++; if (strm.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", strm.out_valid); end
        tests++; if (strm.out_data !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", strm.out_data); end
        tests++; if (strm.out_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b expected 0", strm.out_last); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_full_window();
        int bad = 0, lasts = 0, last_cyc;
        collect(0, 450, 1'b0, 100, -1, -1);
        foreach (bq_val[i]) begin
            if (bq_val[i] != i) bad++;
            if (bq_last[i]) lasts++;
        end
        last_cyc = (bq_cyc.size() > 0) ? bq_cyc[bq_cyc.size()-1] : -1;
        tests++; if (timeout != 0) begin fails++; $display("FAIL full_timeout: got %0d expected 0", timeout); end
        tests++; if (first_valid != 4) begin fails++; $display("FAIL full_latency: got T+%0d expected T+4", first_valid); end
        tests++; if (bq_val.size() != 450) begin fails++; $display("FAIL full_beats: got %0d expected 450", bq_val.size()); end
        tests++; if (bad != 0) begin fails++; $display("FAIL full_order: got %0d wrong beats expected 0", bad); end
        tests++; if (lasts != 1 || !(bq_last.size() == 450 && bq_last[449])) begin fails++; $display("FAIL full_last: got %0d last flags expected 1 on beat 449", lasts); end
        tests++; if (last_cyc != 453) begin fails++; $display("FAIL full_throughput: final beat at T+%0d expected T+453", last_cyc); end
        tests++; if (done_cyc != 454) begin fails++; $display("FAIL full_done_time: got T+%0d expected T+454", done_cyc); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
        tests++; if (busy_at_done != 0) begin fails++; $display("FAIL full_busy_at_done: got %0d expected 0", busy_at_done); end
        tests++; if (bad_uniform != 0) begin fails++; $display("FAIL full_elements: got %0d mixed vectors expected 0", bad_uniform); end
    endtask

    task automatic test_wrap();
        int exp_v[4] = '{448, 449, 0, 1};
        bit exp_l[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int bad = 0;
        collect(448, 4, 1'b0, 100, -1, -1);
        tests++; if (bq_val.size() != 4) begin fails++; $display("FAIL wrap_beats: got %0d expected 4", bq_val.size()); end
        for (int i = 0; i < 4 && i < bq_val.size(); i++)
            if (bq_val[i] != exp_v[i] || bq_last[i] != exp_l[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL wrap_seq: got %0d wrong beats expected 0", bad); end
        tests++; if (done_cnt != 1 || timeout != 0) begin fails++; $display("FAIL wrap_done: got %0d done pulses expected 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int bad = 0, lasts = 0;
        collect(0, 450, 1'b0, 50, -1, -1);
        foreach (bq_val[i]) begin
            if (bq_val[i] != i) bad++;
            if (bq_last[i]) lasts++;
        end
        tests++; if (bq_val.size() != 450) begin fails++; $display("FAIL bp_beats: got %0d expected 450", bq_val.size()); end
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_order: got %0d wrong beats expected 0", bad); end
        tests++; if (stall_viol != 0) begin fails++; $display("FAIL bp_hold: got %0d unstable stalls expected 0", stall_viol); end
        tests++; if (lasts != 1) begin fails++; $display("FAIL bp_last: got %0d last flags expected 1", lasts); end
        tests++; if (done_cyc < 0 || bq_cyc.size() == 0 || done_cyc != bq_cyc[bq_cyc.size()-1] + 1) begin fails++; $display("FAIL bp_done_time: got T+%0d expected one after final beat", done_cyc); end
    endtask

    task automatic test_loop_stop();
        int bad = 0;
        collect(10, 3, 1'b1, 100, 5, -1);
        tests++; if (bq_val.size() != 6) begin fails++; $display("FAIL loop_beats: got %0d expected 6", bq_val.size()); end
        foreach (bq_val[i])
            if (bq_val[i] != 10 + (i % 3) || bq_last[i] != ((i % 3) == 2)) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL loop_seq: got %0d wrong beats expected 0", bad); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL loop_done: got %0d expected 1", done_cnt); end
        tests++; if (extra_valid != 0) begin fails++; $display("FAIL loop_trailing_valid: got %0d expected 0", extra_valid); end
    endtask

    task automatic test_zero_len();
        collect(0, 0, 1'b0, 100, -1, -1);
        tests++; if (done_cyc != 1) begin fails++; $display("FAIL zero_done_time: got T+%0d expected T+1", done_cyc); end
        tests++; if (first_valid != -1) begin fails++; $display("FAIL zero_valid: got valid at T+%0d expected never", first_valid); end
        tests++; if (busy_seen != 0) begin fails++; $display("FAIL zero_busy: got %0d expected 0", busy_seen); end
    endtask

    task automatic test_ignored_start();
        int bad = 0;
        collect(20, 5, 1'b0, 100, -1, 3);
        tests++; if (bq_val.size() != 5) begin fails++; $display("FAIL restart_beats: got %0d expected 5", bq_val.size()); end
        foreach (bq_val[i]) if (bq_val[i] != 20 + i) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL restart_seq: got %0d wrong beats expected 0", bad); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL restart_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        int n = 0, seen_done = 0, seen_valid = 0;
        cfg_base = ADDR_W'(30); cfg_len = (ADDR_W+1)'(4); cfg_loop = 1'b0;
        strm.out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        while (!strm.out_valid && n < 20) begin tick(); n++; end
        tests++; if (strm.out_valid !== 1'b1) begin fails++; $display("FAIL rst_stall_setup: got %b expected 1", strm.out_valid); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tests++; if (strm.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", strm.out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        repeat (8) begin
            if (done) seen_done++;
            if (strm.out_valid) seen_valid++;
            tick();
        end
        tests++; if (seen_done != 0 || seen_valid != 0) begin fails++; $display("FAIL rst_mid_quiet: got %0d done %0d valid expected 0 0", seen_done, seen_valid); end
        collect(5, 2, 1'b0, 100, -1, -1);
        tests++; if (bq_val.size() != 2 || bq_val[0] != 5 || bq_val[1] != 6) begin fails++; $display("FAIL rst_follow_seq: got %0d beats first %0d expected 2 beats 5,6", bq_val.size(), (bq_val.size() > 0) ? bq_val[0] : -1); end
        tests++; if (bq_last.size() != 2 || bq_last[0] || !bq_last[1]) begin fails++; $display("FAIL rst_follow_last: got %0d beats expected last on beat 1", bq_last.size()); end
    endtask

    initial begin
        strm.out_ready = 1'b0;
        test_reset();
        load_all();
        test_full_window();
        test_wrap();
        test_backpressure();
        test_loop_stop();
        test_zero_len();
        test_ignored_start();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
